// File: rtl/i2c_pkg.sv
// Shared definitions for the two-requester I2C master arbiter: controller states,
// parameter defaults and the round-robin pick rule.
package i2c_pkg;

  localparam int unsigned LenWDefault          = 4;
  localparam int unsigned TimeoutCyclesDefault = 4096;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StAddr = 2'd1,
    StData = 2'd2,
    StStop = 2'd3
  } i2c_state_e;

  // Winner index for two requesters; prefer_idx breaks a tie.
  function automatic logic rr_pick(input logic [1:0] req, input logic prefer_idx);
    logic pick;
    if (req == 2'b11) begin
      pick = prefer_idx;
    end else begin
      pick = req[1];
    end
    return pick;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin arbiter; remembers which requester should win the next tie.
module rr_arb2
  import i2c_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [1:0] req_i,
  input  logic       upd_i,
  input  logic       upd_idx_i,
  output logic       idx_o
);

  logic prefer_q, prefer_d;

  always_comb begin
    idx_o    = rr_pick(req_i, prefer_q);
    prefer_d = prefer_q;
    // The requester just served loses the next tie.
    if (upd_i) begin
      prefer_d = ~upd_idx_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      prefer_q <= 1'b0;
    end else begin
      prefer_q <= prefer_d;
    end
  end

endmodule

// File: rtl/i2c_arbiter.sv
// Shares one I2C byte-level master between two write requesters: round-robin grant,
// address/data/stop sequencing and a no-progress watchdog.
module i2c_arbiter
  import i2c_pkg::*;
#(
  parameter int unsigned LEN_W          = LenWDefault,
  parameter int unsigned TIMEOUT_CYCLES = TimeoutCyclesDefault
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0,
  input  logic             req1,
  input  logic [7:0]       addr0,
  input  logic [7:0]       addr1,
  input  logic [7:0]       wdat0,
  input  logic [7:0]       wdat1,
  input  logic [LEN_W-1:0] len0,
  input  logic [LEN_W-1:0] len1,
  output logic             gnt0,
  output logic             gnt1,
  output logic             nxt0,
  output logic             nxt1,
  output logic             done0,
  output logic             done1,
  output logic             err,
  output logic             m_start,
  output logic [7:0]       m_addr,
  output logic [7:0]       m_dat,
  input  logic             m_busy,
  input  logic             m_running,
  input  logic             m_addr_sent,
  output logic             m_restart
);

  localparam int unsigned    CntW    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYCLES - 1);

  i2c_state_e       state_q, state_d;
  logic             owner_q, owner_d;
  logic [7:0]       addr_q, addr_d;
  logic [LEN_W-1:0] rem_q, rem_d;
  logic [CntW-1:0]  wdog_q, wdog_d;
  logic             busy_q, addr_sent_q;

  logic arb_idx;
  logic busy_fall, addr_sent_rise, timeout;
  logic start, nxt, done;

  rr_arb2 u_rr_arb2 (
    .clk_i     (clk),
    .rst_ni    (rst),
    .req_i     ({req1, req0}),
    .upd_i     (done),
    .upd_idx_i (owner_q),
    .idx_o     (arb_idx)
  );

  assign busy_fall      = busy_q & ~m_busy;
  assign addr_sent_rise = m_addr_sent & ~addr_sent_q;
  assign timeout        = (state_q != StIdle) && (wdog_q == CntLast);

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    addr_d  = addr_q;
    rem_d   = rem_q;
    start   = 1'b0;
    nxt     = 1'b0;
    done    = 1'b0;
    err     = 1'b0;

    unique case (state_q)
      StIdle: begin
        if ((req0 || req1) && !m_running) begin
          state_d = StAddr;
          owner_d = arb_idx;
          addr_d  = arb_idx ? addr1 : addr0;
          rem_d   = arb_idx ? len1 : len0;
        end
      end
      StAddr: begin
        start = 1'b1;
        if (m_addr_sent) begin
          state_d = (rem_q == '0) ? StStop : StData;
        end
      end
      StData: begin
        start = 1'b1;
        if (busy_fall) begin
          nxt   = 1'b1;
          rem_d = rem_q - 1'b1;
          if (rem_q == LEN_W'(1)) begin
            state_d = StStop;
          end
        end
      end
      StStop: begin
        if (!m_running) begin
          done    = 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    // Watchdog abort overrides whatever the sequencer wanted this cycle.
    if (timeout) begin
      start   = 1'b0;
      nxt     = 1'b0;
      done    = 1'b1;
      err     = 1'b1;
      rem_d   = rem_q;
      state_d = StIdle;
    end
  end

  always_comb begin
    wdog_d = wdog_q + 1'b1;
    if (state_q == StIdle || state_d != state_q || addr_sent_rise || busy_fall) begin
      wdog_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StIdle;
      owner_q     <= 1'b0;
      addr_q      <= 8'h00;
      rem_q       <= '0;
      wdog_q      <= '0;
      busy_q      <= 1'b0;
      addr_sent_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      addr_q      <= addr_d;
      rem_q       <= rem_d;
      wdog_q      <= wdog_d;
      busy_q      <= m_busy;
      addr_sent_q <= m_addr_sent;
    end
  end

  assign gnt0      = (state_q != StIdle) & ~owner_q;
  assign gnt1      = (state_q != StIdle) & owner_q;
  assign nxt0      = nxt & ~owner_q;
  assign nxt1      = nxt & owner_q;
  assign done0     = done & ~owner_q;
  assign done1     = done & owner_q;
  assign m_start   = start;
  assign m_addr    = addr_q;
  assign m_dat     = gnt1 ? wdat1 : (gnt0 ? wdat0 : 8'h00);
  assign m_restart = 1'b0;

endmodule
